// File: rtl/hwpe_dma_seq.sv
// -----------------------------------------------------------------------------
// hwpe_dma_seq
//
// Autonomous load sequencer for the HWPE. One start command makes it fetch
// 64-bit words from an external read port and stream them into the HWPE SRAM
// write port in three phases:
//   FMAP1 : fmap_base               -> HWPE address 0
//   FMAP2 : fmap_base + fmap2_off   -> FMEM_ADDR2_START
//   KERN  : kernel_base             -> KMEM_ADDR_START
// Empty phases are skipped. When the last write has retired a single-cycle
// done pulse is produced so the MCU can start issuing EAI instructions.
//
// Parameters
//   ADDR_WIDTH        width of dma_wa (must match the HWPE address width)
//   FMEM_ADDR2_START  HWPE byte address of fmap bank 2
//   KMEM_ADDR_START   HWPE byte address of the kernel SRAM
//   MAX_OUT           maximum outstanding read requests (1..8)
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      one-cycle command, fields sampled when !busy
//   fmap_base, fmap2_off       source address of bank 1, offset of bank 2
//   fmap_words                 64-bit words per fmap bank
//   kernel_base, kernel_words  source address / word count of kernel data
//   busy, done                 sequence status, done is a one-cycle pulse
//   rd_req_valid/ready/addr    read request channel (valid/ready handshake)
//   rd_rsp_valid/data          in-order read response, no back-pressure
//   dma_wen/dma_wa/dma_wd      HWPE SRAM write port (registered)
//   chksum                     running XOR of written words
//
// Build option
//   HWPE_DMA_SEQ_CHKSUM_EN     when defined, chksum accumulates the XOR of
//                              every written word since the last accepted
//                              start; otherwise chksum is tied to zero.
// -----------------------------------------------------------------------------
module hwpe_dma_seq #(
  parameter int unsigned            ADDR_WIDTH       = 16,
  parameter logic [ADDR_WIDTH-1:0]  FMEM_ADDR2_START = 16'h4000,
  parameter logic [ADDR_WIDTH-1:0]  KMEM_ADDR_START  = 16'h8000,
  parameter int unsigned            MAX_OUT          = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  start,
  input  logic [31:0]           fmap_base,
  input  logic [31:0]           fmap2_off,
  input  logic [15:0]           fmap_words,
  input  logic [31:0]           kernel_base,
  input  logic [15:0]           kernel_words,
  output logic                  busy,
  output logic                  done,

  output logic                  rd_req_valid,
  input  logic                  rd_req_ready,
  output logic [31:0]           rd_req_addr,
  input  logic                  rd_rsp_valid,
  input  logic [63:0]           rd_rsp_data,

  output logic                  dma_wen,
  output logic [ADDR_WIDTH-1:0] dma_wa,
  output logic [63:0]           dma_wd,

  output logic [63:0]           chksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FMAP1,
    S_FMAP2,
    S_KERN,
    S_DRAIN,
    S_DONE
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                  state_q, state_d;

  // Command fields captured on an accepted start.
  logic [31:0]             fmap1_src_q, fmap1_src_d;
  logic [31:0]             fmap2_src_q, fmap2_src_d;
  logic [31:0]             kern_src_q,  kern_src_d;
  logic [15:0]             fmap_words_q, fmap_words_d;
  logic [15:0]             kern_words_q, kern_words_d;

  // Per-phase counters: requests issued and responses received.
  logic [15:0]             iss_q, iss_d;
  logic [15:0]             rsp_q, rsp_d;

  // Registered SRAM write port.
  logic                    wen_q, wen_d;
  logic [ADDR_WIDTH-1:0]   wa_q,  wa_d;
  logic [63:0]             wd_q,  wd_d;

  // ---------------------------------------------------------------------------
  // Current-phase decode
  // ---------------------------------------------------------------------------
  logic                    phase_active;
  logic [15:0]             phase_words;
  logic [31:0]             phase_src;
  logic [ADDR_WIDTH-1:0]   phase_dst;

  // NOTE: every signal written in an always_comb gets a default value first,
  // so no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    phase_active = 1'b0;
    phase_words  = '0;
    phase_src    = '0;
    phase_dst    = '0;
    unique case (state_q)
      S_FMAP1: begin
        phase_active = 1'b1;
        phase_words  = fmap_words_q;
        phase_src    = fmap1_src_q;
        phase_dst    = '0;
      end
      S_FMAP2: begin
        phase_active = 1'b1;
        phase_words  = fmap_words_q;
        phase_src    = fmap2_src_q;
        phase_dst    = FMEM_ADDR2_START;
      end
      S_KERN: begin
        phase_active = 1'b1;
        phase_words  = kern_words_q;
        phase_src    = kern_src_q;
        phase_dst    = KMEM_ADDR_START;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request / response handling
  // ---------------------------------------------------------------------------
  logic [15:0]             outstanding;
  logic                    req_fire;
  logic                    rsp_take;
  logic                    phase_end;
  logic                    start_acc;

  assign outstanding  = iss_q - rsp_q;

  // Valid depends only on registered state, so the address stays stable for
  // as long as the request waits for ready.
  assign rd_req_valid = phase_active
                      && (iss_q < phase_words)
                      && (outstanding < 16'(MAX_OUT));
  assign rd_req_addr  = phase_active ? (phase_src + {13'd0, iss_q, 3'd0}) : '0;
  assign req_fire     = rd_req_valid && rd_req_ready;

  // Responses with nothing outstanding (e.g. stragglers from before a reset)
  // are dropped instead of being written somewhere.
  assign rsp_take     = phase_active && rd_rsp_valid && (outstanding != 16'd0);

  // A phase ends only after all its responses have arrived, so no response can
  // ever be attributed to the wrong phase. The final write of the phase is on
  // the port during this cycle.
  assign phase_end    = phase_active && (rsp_q == phase_words);

  assign start_acc    = start && !busy;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    fmap1_src_d  = fmap1_src_q;
    fmap2_src_d  = fmap2_src_q;
    kern_src_d   = kern_src_q;
    fmap_words_d = fmap_words_q;
    kern_words_d = kern_words_q;
    iss_d        = iss_q;
    rsp_d        = rsp_q;
    wen_d        = 1'b0;
    wa_d         = wa_q;
    wd_d         = wd_q;

    if (req_fire) begin
      iss_d = iss_q + 16'd1;
    end

    if (rsp_take) begin
      rsp_d = rsp_q + 16'd1;
      wen_d = 1'b1;
      wa_d  = phase_dst + ADDR_WIDTH'({rsp_q, 3'b000});
      wd_d  = rd_rsp_data;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start_acc) begin
          fmap1_src_d  = fmap_base;
          fmap2_src_d  = fmap_base + fmap2_off;
          kern_src_d   = kernel_base;
          fmap_words_d = fmap_words;
          kern_words_d = kernel_words;
          iss_d        = '0;
          rsp_d        = '0;
          // With nothing to move the sequence still passes through DRAIN so
          // busy is seen for one cycle and done follows two cycles after start.
          if (fmap_words != 16'd0) begin
            state_d = S_FMAP1;
          end else if (kernel_words != 16'd0) begin
            state_d = S_KERN;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end

      S_FMAP1: begin
        // FMAP2 shares the word count, so it is never empty here.
        if (phase_end) begin
          state_d = S_FMAP2;
          iss_d   = '0;
          rsp_d   = '0;
        end
      end

      S_FMAP2: begin
        if (phase_end) begin
          iss_d = '0;
          rsp_d = '0;
          if (kern_words_q != 16'd0) begin
            state_d = S_KERN;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end

      S_KERN: begin
        if (phase_end) begin
          state_d = S_DRAIN;
          iss_d   = '0;
          rsp_d   = '0;
        end
      end

      // One extra cycle so the last write has retired before done.
      S_DRAIN: state_d = S_DONE;

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the values of the previous cycle regardless of the
  // order in which the simulator evaluates processes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      fmap1_src_q  <= '0;
      fmap2_src_q  <= '0;
      kern_src_q   <= '0;
      fmap_words_q <= '0;
      kern_words_q <= '0;
      iss_q        <= '0;
      rsp_q        <= '0;
      wen_q        <= 1'b0;
      wa_q         <= '0;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      fmap1_src_q  <= fmap1_src_d;
      fmap2_src_q  <= fmap2_src_d;
      kern_src_q   <= kern_src_d;
      fmap_words_q <= fmap_words_d;
      kern_words_q <= kern_words_d;
      iss_q        <= iss_d;
      rsp_q        <= rsp_d;
      wen_q        <= wen_d;
      wa_q         <= wa_d;
      wd_q         <= wd_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy    = (state_q == S_FMAP1) || (state_q == S_FMAP2)
                || (state_q == S_KERN)  || (state_q == S_DRAIN);
  assign done    = (state_q == S_DONE);
  assign dma_wen = wen_q;
  assign dma_wa  = wa_q;
  assign dma_wd  = wd_q;

`ifdef HWPE_DMA_SEQ_CHKSUM_EN
  logic [63:0] chk_q, chk_d;

  // Accumulates the word actually presented on the write port; the last
  // write is folded in before done, so the value is final while done is high.
  always_comb begin
    chk_d = chk_q;
    if (start_acc) begin
      chk_d = '0;
    end else if (wen_q) begin
      chk_d = chk_q ^ wd_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_q <= '0;
    end else begin
      chk_q <= chk_d;
    end
  end

  assign chksum = chk_q;
`else
  assign chksum = 64'h0;
`endif

endmodule

// File: tb/tb_hwpe_dma_seq.sv
// -----------------------------------------------------------------------------
// tb_hwpe_dma_seq
//
// Self-checking bench for hwpe_dma_seq. A read-port model answers requests
// after a configurable latency with randomised ready; the expected list of
// read addresses and SRAM writes is derived from the command fields alone.
// A table of directed commands is followed by random commands and by
// hand-written sequences for a start while busy and a reset mid-transfer.
// -----------------------------------------------------------------------------
module tb_hwpe_dma_seq;

  localparam int              AW      = 16;
  localparam int              MAX_OUT = 4;
  localparam logic [AW-1:0]   FMEM2   = 16'h4000;
  localparam logic [AW-1:0]   KMEM    = 16'h8000;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [31:0]   fmap_base;
  logic [31:0]   fmap2_off;
  logic [15:0]   fmap_words;
  logic [31:0]   kernel_base;
  logic [15:0]   kernel_words;
  logic          busy;
  logic          done;
  logic          rd_req_valid;
  logic          rd_req_ready;
  logic [31:0]   rd_req_addr;
  logic          rd_rsp_valid;
  logic [63:0]   rd_rsp_data;
  logic          dma_wen;
  logic [AW-1:0] dma_wa;
  logic [63:0]   dma_wd;
  logic [63:0]   chksum;

  hwpe_dma_seq #(
    .ADDR_WIDTH       (AW),
    .FMEM_ADDR2_START (FMEM2),
    .KMEM_ADDR_START  (KMEM),
    .MAX_OUT          (MAX_OUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .fmap_base    (fmap_base),
    .fmap2_off    (fmap2_off),
    .fmap_words   (fmap_words),
    .kernel_base  (kernel_base),
    .kernel_words (kernel_words),
    .busy         (busy),
    .done         (done),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_addr  (rd_req_addr),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_data  (rd_rsp_data),
    .dma_wen      (dma_wen),
    .dma_wa       (dma_wa),
    .dma_wd       (dma_wd),
    .chksum       (chksum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Source memory contents: a fixed function of the byte address, so a word
  // fetched from the wrong address is visible in the written data.
  function automatic logic [63:0] mem_data(input logic [31:0] a);
    return {a ^ 32'hC0DE_5A5A, (~a) + 32'h0000_1357};
  endfunction

  // ---------------------------------------------------------------------------
  // Read-port model and output monitor
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic [AW-1:0] wa;
    logic [63:0]   wd;
  } wr_t;

  pend_t       pend_q[$];
  wr_t         wr_log[$];
  logic [31:0] req_log[$];
  int          cyc          = 0;
  int          lat          = 1;
  int          ready_pct    = 100;
  bit          inc_mode     = 1'b0;
  int          rsp_idx      = 0;
  int          done_cnt     = 0;
  int          done_cyc     = -1;
  int          busy_cnt     = 0;
  int          max_out      = 0;
  int          last_wen_cyc = -1;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    pend_t       p;
    bit          hold_valid;
    logic [31:0] hold_addr;
    hold_valid   = 1'b0;
    hold_addr    = '0;
    rd_req_ready = 1'b0;
    rd_rsp_valid = 1'b0;
    rd_rsp_data  = '0;
    forever begin
      @(negedge clk);
      // Monitor: DUT outputs have been stable since the rising edge.
      if (dma_wen) begin
        wr_log.push_back('{wa: dma_wa, wd: dma_wd});
        last_wen_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_cnt++;

      // Response for this cycle.
      rd_rsp_valid = 1'b0;
      rd_rsp_data  = '0;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        p = pend_q.pop_front();
        rsp_idx++;
        rd_rsp_valid = 1'b1;
        rd_rsp_data  = inc_mode ? 64'(rsp_idx) : mem_data(p.addr);
      end

      // A stalled request must stay up with the same address.
      if (hold_valid && rst_n) begin
        check("req_valid_held", rd_req_valid, 1);
        check("req_addr_stable", rd_req_addr, hold_addr);
      end

      rd_req_ready = ($urandom_range(99) < ready_pct);
      hold_valid   = rd_req_valid && !rd_req_ready && rst_n;
      hold_addr    = rd_req_addr;

      // Handshake that completes at the coming rising edge.
      if (rd_req_valid && rd_req_ready) begin
        pend_q.push_back('{addr: rd_req_addr, due: cyc + lat});
        req_log.push_back(rd_req_addr);
        if (pend_q.size() > max_out) max_out = pend_q.size();
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: expected reads and writes from the command alone
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0]   fb;
    logic [31:0]   off;
    logic [15:0]   fw;
    logic [31:0]   kb;
    logic [15:0]   kw;
    int            lat;
    int            rdy;
    bit            inc;
    int            exp_n;        // total SRAM writes
    logic [AW-1:0] exp_last_wa;  // address of final write (exp_n > 0)
    int            exp_gap;      // done cycle minus last write cycle, 0 = skip
    int            exp_sd;       // done cycle minus start cycle, 0 = skip
    int            exp_max;      // peak outstanding reads, 0 = skip
  } vec_t;

  logic [31:0]   exp_req[$];
  logic [AW-1:0] exp_wa[$];
  logic [63:0]   exp_wd[$];
  logic [63:0]   exp_chk;

  task automatic build_model(input vec_t v);
    int          words;
    int          k;
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] a;
    exp_req.delete();
    exp_wa.delete();
    exp_wd.delete();
    exp_chk = '0;
    k = 0;
    for (int ph = 0; ph < 3; ph++) begin
      words = (ph == 2) ? int'(v.kw) : int'(v.fw);
      src   = (ph == 0) ? v.fb : (ph == 1) ? v.fb + v.off : v.kb;
      dst   = (ph == 0) ? 32'h0 : (ph == 1) ? 32'(FMEM2) : 32'(KMEM);
      for (int i = 0; i < words; i++) begin
        a = src + 32'(i * 8);
        exp_req.push_back(a);
        exp_wa.push_back(AW'(dst + 32'(i * 8)));
        exp_wd.push_back(v.inc ? 64'(k + 1) : mem_data(a));
        k++;
      end
    end
`ifdef HWPE_DMA_SEQ_CHKSUM_EN
    foreach (exp_wd[i]) exp_chk = exp_chk ^ exp_wd[i];
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Sequence helpers
  // ---------------------------------------------------------------------------
  task automatic clear_logs();
    wr_log.delete();
    req_log.delete();
    done_cnt     = 0;
    done_cyc     = -1;
    busy_cnt     = 0;
    max_out      = 0;
    rsp_idx      = 0;
    last_wen_cyc = -1;
  endtask

  // Called at a falling edge; returns at the falling edge of cycle T+1.
  task automatic issue_start(input vec_t v, input string tag, output int start_cyc);
    lat          = v.lat;
    ready_pct    = v.rdy;
    inc_mode     = v.inc;
    fmap_base    = v.fb;
    fmap2_off    = v.off;
    fmap_words   = v.fw;
    kernel_base  = v.kb;
    kernel_words = v.kw;
    start        = 1'b1;
    start_cyc    = cyc;
    @(negedge clk);
    start        = 1'b0;
    check({tag, "_busy_t1"}, busy, 1);
    check({tag, "_req_valid_t1"}, rd_req_valid, (v.exp_n > 0));
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_done_seen"}, (done_cnt != 0), 1);
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic check_run(input vec_t v, input string tag, input int start_cyc);
    check({tag, "_n_writes"}, wr_log.size(), v.exp_n);
    check({tag, "_n_writes_model"}, wr_log.size(), exp_wa.size());
    for (int i = 0; i < wr_log.size() && i < exp_wa.size(); i++) begin
      check($sformatf("%s_wa[%0d]", tag, i), wr_log[i].wa, exp_wa[i]);
      check($sformatf("%s_wd[%0d]", tag, i), wr_log[i].wd, exp_wd[i]);
    end
    if (v.exp_n > 0 && wr_log.size() > 0)
      check({tag, "_last_wa"}, wr_log[wr_log.size()-1].wa, v.exp_last_wa);
    check({tag, "_n_reqs"}, req_log.size(), exp_req.size());
    for (int i = 0; i < req_log.size() && i < exp_req.size(); i++)
      check($sformatf("%s_req[%0d]", tag, i), req_log[i], exp_req[i]);
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_busy_cycles"}, busy_cnt, done_cyc - start_cyc - 1);
    check({tag, "_busy_low_after"}, busy, 0);
    check({tag, "_chksum"}, chksum, exp_chk);
    check({tag, "_max_out_limit"}, (max_out <= MAX_OUT), 1);
    if (v.exp_gap != 0) check({tag, "_done_after_wen"}, done_cyc - last_wen_cyc, v.exp_gap);
    if (v.exp_sd != 0)  check({tag, "_done_after_start"}, done_cyc - start_cyc, v.exp_sd);
    if (v.exp_max != 0) check({tag, "_max_out"}, max_out, v.exp_max);
  endtask

  function automatic vec_t derive_expect(input vec_t v);
    vec_t r;
    r             = v;
    r.exp_n       = 2 * int'(v.fw) + int'(v.kw);
    r.exp_last_wa = (v.kw != 0) ? KMEM  + AW'(8 * (int'(v.kw) - 1)) :
                    (v.fw != 0) ? FMEM2 + AW'(8 * (int'(v.fw) - 1)) : '0;
    r.exp_gap     = (r.exp_n > 0) ? 2 : 0;
    r.exp_sd      = (r.exp_n == 0) ? 2 : 0;
    r.exp_max     = 0;
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Main test
  // ---------------------------------------------------------------------------
  vec_t vecs[6];

  initial begin
    vec_t v;
    vec_t g;
    int   sc;
    int   n;

    vecs[0] = '{fb: 32'h1000_0000, off: 32'h0000_0100, fw: 16'd3, kb: 32'h2000_0000, kw: 16'd2,
                lat: 1, rdy: 100, inc: 1'b1, exp_n: 8, exp_last_wa: 16'h8008,
                exp_gap: 2, exp_sd: 0, exp_max: 0};
    vecs[1] = '{fb: 32'h1000_0000, off: 32'h0000_0100, fw: 16'd0, kb: 32'h2000_0000, kw: 16'd0,
                lat: 1, rdy: 100, inc: 1'b0, exp_n: 0, exp_last_wa: 16'h0000,
                exp_gap: 0, exp_sd: 2, exp_max: 0};
    vecs[2] = '{fb: 32'h1000_0000, off: 32'h0000_0100, fw: 16'd0, kb: 32'h3000_0040, kw: 16'd5,
                lat: 1, rdy: 100, inc: 1'b0, exp_n: 5, exp_last_wa: 16'h8020,
                exp_gap: 2, exp_sd: 0, exp_max: 0};
    vecs[3] = '{fb: 32'h1000_0000, off: 32'h0000_0100, fw: 16'd3, kb: 32'h2000_0000, kw: 16'd2,
                lat: 6, rdy: 50, inc: 1'b0, exp_n: 8, exp_last_wa: 16'h8008,
                exp_gap: 2, exp_sd: 0, exp_max: 0};
    vecs[4] = '{fb: 32'hFFFF_FFF8, off: 32'h0000_0008, fw: 16'd1, kb: 32'hFFFF_FFF0, kw: 16'd4,
                lat: 2, rdy: 100, inc: 1'b0, exp_n: 6, exp_last_wa: 16'h8018,
                exp_gap: 2, exp_sd: 0, exp_max: 0};
    vecs[5] = '{fb: 32'h0400_0000, off: 32'h0001_0000, fw: 16'd3, kb: 32'h0500_0000, kw: 16'd4,
                lat: 6, rdy: 100, inc: 1'b0, exp_n: 10, exp_last_wa: 16'h8018,
                exp_gap: 2, exp_sd: 0, exp_max: MAX_OUT};

    rst_n        = 1'b0;
    start        = 1'b0;
    fmap_base    = '0;
    fmap2_off    = '0;
    fmap_words   = '0;
    kernel_base  = '0;
    kernel_words = '0;
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst_busy",      busy,         0);
    check("rst_done",      done,         0);
    check("rst_req_valid", rd_req_valid, 0);
    check("rst_req_addr",  rd_req_addr,  0);
    check("rst_wen",       dma_wen,      0);
    check("rst_wa",        dma_wa,       0);
    check("rst_wd",        dma_wd,       0);
    check("rst_chksum",    chksum,       0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      build_model(vecs[i]);
      clear_logs();
      issue_start(vecs[i], $sformatf("vec%0d", i), sc);
      wait_done(400, $sformatf("vec%0d", i));
      check_run(vecs[i], $sformatf("vec%0d", i), sc);
    end

    // Random commands.
    for (int r = 0; r < 16; r++) begin
      v.fb  = $urandom() & 32'hFFFF_FFF8;
      v.off = $urandom() & 32'h000F_FFF8;
      v.fw  = 16'($urandom_range(0, 5));
      v.kb  = $urandom() & 32'hFFFF_FFF8;
      v.kw  = 16'($urandom_range(0, 5));
      v.lat = $urandom_range(1, 7);
      v.rdy = $urandom_range(30, 100);
      v.inc = 1'b0;
      v     = derive_expect(v);
      build_model(v);
      clear_logs();
      issue_start(v, $sformatf("rnd%0d", r), sc);
      wait_done(600, $sformatf("rnd%0d", r));
      check_run(v, $sformatf("rnd%0d", r), sc);
    end

    // Second start while FMAP2 is running must be ignored.
    v     = vecs[0];
    v.inc = 1'b0;
    build_model(v);
    clear_logs();
    issue_start(v, "restart", sc);
    n = 0;
    while (!(dma_wen && dma_wa == FMEM2) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("restart_in_fmap2", (dma_wen && dma_wa == FMEM2), 1);
    g.fb = 32'h5000_0000; g.off = 32'h20; g.fw = 16'd7; g.kb = 32'h6000_0000; g.kw = 16'd1;
    fmap_base    = g.fb;
    fmap2_off    = g.off;
    fmap_words   = g.fw;
    kernel_base  = g.kb;
    kernel_words = g.kw;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    wait_done(400, "restart");
    check_run(v, "restart", sc);

    // Reset with three reads outstanding in FMAP1.
    v = '{fb: 32'h0800_0000, off: 32'h0000_0400, fw: 16'd8, kb: 32'h0900_0000, kw: 16'd0,
          lat: 6, rdy: 100, inc: 1'b0, exp_n: 16, exp_last_wa: 16'h4038,
          exp_gap: 2, exp_sd: 0, exp_max: 0};
    clear_logs();
    issue_start(v, "rstmid", sc);
    n = 0;
    while (pend_q.size() != 3 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rstmid_three_outstanding", pend_q.size(), 3);
    rst_n = 1'b0;
    #1;
    check("rstmid_busy",      busy,         0);
    check("rstmid_done",      done,         0);
    check("rstmid_req_valid", rd_req_valid, 0);
    check("rstmid_req_addr",  rd_req_addr,  0);
    check("rstmid_wen",       dma_wen,      0);
    check("rstmid_wa",        dma_wa,       0);
    check("rstmid_wd",        dma_wd,       0);
    check("rstmid_chksum",    chksum,       0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr_log.delete();
    n = 0;
    while (pend_q.size() != 0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    repeat (3) @(negedge clk);
    #1;
    check("rstmid_late_rsp_drained", pend_q.size(), 0);
    check("rstmid_late_rsp_no_write", wr_log.size(), 0);
    check("rstmid_no_done", done_cnt, 0);

    v.fw      = 16'd3;
    v.kw      = 16'd2;
    v.lat     = 1;
    v         = derive_expect(v);
    build_model(v);
    clear_logs();
    issue_start(v, "after_rst", sc);
    wait_done(400, "after_rst");
    check_run(v, "after_rst", sc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
